// File: rtl/controlador_serie_mealy.sv
// Bit-serial sequencer around an external next-state block: shifts a word MSB-first
// on I_out, holds the 1-bit state register y, and gathers every Y_in into resultado.
module controlador_serie_mealy #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dato,
  input  logic             modo,
  output logic             I_out,
  output logic             S_out,
  output logic             y_out,
  input  logic             Y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             modo_q, modo_d;
  logic             y_q, y_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      modo_q  <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    modo_d  = modo_q;
    y_d     = y_q;
    I_out   = 1'b0;
    S_out   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = dato;
          modo_d  = modo;
          y_d     = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        I_out   = shreg_q[WIDTH-1];
        S_out   = modo_q;
        busy    = 1'b1;
        y_d     = Y_in;
        res_d   = {res_q[WIDTH-2:0], Y_in};
        shreg_d = shreg_q << 1;
        // Counter parks on its last value instead of wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign y_out     = y_q;
  assign resultado = res_q;

endmodule
